mandel_param_rx: RTL and testbench



---
 rtl/mandel_pkg.sv | 47 ++++
 rtl/mandel_param_rx_if.sv | 37 +++
 rtl/mandel_param_rx.sv | 139 +++++++++++++
 tb/tb_mandel_param_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mandel_pkg
// Purpose  : Shared constants and types for the Mandelbrot command-frame path.
//            Frame layout (byte offsets), field widths, FSM state encoding and
//            the assembled parameter-frame record.
// Revision : 1.0  initial release
// ============================================================================
package mandel_pkg;

    localparam int FRAME_LEN        = 10;
    localparam int PIX_W            = 8;
    localparam int COORD_W          = 16;
    localparam int UART_CLK_PER_BIT = 26;

    // Byte index width: enough for offsets 0..FRAME_LEN-1
    localparam int IDX_W = 4;

    // Byte offsets within the frame; 16-bit fields arrive high byte first
    localparam logic [IDX_W-1:0] OFS_PIX_X = 4'd0;
    localparam logic [IDX_W-1:0] OFS_PIX_Y = 4'd1;
    localparam logic [IDX_W-1:0] OFS_CXS_H = 4'd2;
    localparam logic [IDX_W-1:0] OFS_CXS_L = 4'd3;
    localparam logic [IDX_W-1:0] OFS_CYS_H = 4'd4;
    localparam logic [IDX_W-1:0] OFS_CYS_L = 4'd5;
    localparam logic [IDX_W-1:0] OFS_DCX_H = 4'd6;
    localparam logic [IDX_W-1:0] OFS_DCX_L = 4'd7;
    localparam logic [IDX_W-1:0] OFS_DCY_H = 4'd8;
    localparam logic [IDX_W-1:0] OFS_DCY_L = 4'd9;

    // Receiver FSM encoding
    localparam int               ST_W       = 1;
    localparam logic [ST_W-1:0]  ST_COLLECT = 1'b0;
    localparam logic [ST_W-1:0]  ST_PENDING = 1'b1;

    // Assembled parameter frame; coordinate fields are raw two's complement
    typedef struct packed {
        logic        [PIX_W-1:0]   pix_x;
        logic        [PIX_W-1:0]   pix_y;
        logic signed [COORD_W-1:0] cxs;
        logic signed [COORD_W-1:0] cys;
        logic signed [COORD_W-1:0] dcx;
        logic signed [COORD_W-1:0] dcy;
    } frame_t;

endpackage
`default_nettype wire

// File: rtl/mandel_param_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : mandel_param_rx_if
// Purpose  : Parameter-frame handshake between the frame assembler and the
//            Mandelbrot iteration core.
//   frame_valid       complete frame held on the parameter lines
//   frame_ready       core accepts the frame
//   pix_x, pix_y      pixel coordinates
//   cxs, cys          signed start point (real / imaginary)
//   dcx, dcy          signed step (real / imaginary)
//   master : frame producer (assembler)   slave : frame consumer (core)
// Revision : 1.0  initial release
// ============================================================================
interface mandel_param_rx_if;
    import mandel_pkg::*;

    logic                      frame_valid;
    logic                      frame_ready;
    logic        [PIX_W-1:0]   pix_x;
    logic        [PIX_W-1:0]   pix_y;
    logic signed [COORD_W-1:0] cxs;
    logic signed [COORD_W-1:0] cys;
    logic signed [COORD_W-1:0] dcx;
    logic signed [COORD_W-1:0] dcy;

    modport master (
        output frame_valid, pix_x, pix_y, cxs, cys, dcx, dcy,
        input  frame_ready
    );

    modport slave (
        input  frame_valid, pix_x, pix_y, cxs, cys, dcx, dcy,
        output frame_ready
    );

endinterface
`default_nettype wire

// File: rtl/mandel_param_rx.sv
`default_nettype none
// ============================================================================
// Module   : mandel_param_rx
// Purpose  : Assembles the 10-byte Mandelbrot parameter frame from the UART
//            byte stream and offers it to the core over valid/ready.
//            A mid-frame inter-byte timeout resynchronises framing; bytes
//            arriving while a finished frame waits for acceptance are dropped.
// Ports    :
//   clk, rst        clock, synchronous active-high reset
//   rx_data/valid   received byte + one-cycle strobe
//   frm (master)    frame handshake and parameter fields
//   frame_err       pulse: partial frame discarded on timeout
//   ovf_err         pulse: byte dropped while frame pending
//   frame_cnt       accepted-frame count, wraps 255 -> 0
// Revision : 1.0  initial release
// ============================================================================
module mandel_param_rx
    import mandel_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2600
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [7:0]   rx_data,
    input  wire logic         rx_valid,
    mandel_param_rx_if.master frm,
    output logic              frame_err,
    output logic              ovf_err,
    output logic [7:0]        frame_cnt
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [15:0]      c_TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_tmo;
    frame_t           r_frame;
    logic             r_frame_err;
    logic             r_ovf_err;
    logic [7:0]       r_frame_cnt;

    logic w_frame_valid;
    logic w_hs;
    logic w_store;
    logic w_drop;
    logic w_counting;
    logic w_tmo_hit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: if (rx_valid && (r_idx == c_LAST_IDX)) w_state_nxt = ST_PENDING;
            ST_PENDING: if (frm.frame_ready)                   w_state_nxt = ST_COLLECT;
            default:    w_state_nxt = ST_COLLECT;
        endcase
    end

    // ---------------- FSM: outputs / control ----------------
    always_comb begin
        w_frame_valid = (r_state == ST_PENDING);
        w_hs          = w_frame_valid && frm.frame_ready;
        // A byte arriving in the handshake cycle opens the next frame (idx is 0)
        w_store       = rx_valid && (!w_frame_valid || w_hs);
        w_drop        = rx_valid && w_frame_valid && !frm.frame_ready;
        w_counting    = !w_frame_valid && (r_idx != '0);
        // A strobe in the expiry cycle wins over the timeout
        w_tmo_hit     = w_counting && !rx_valid && (r_tmo == c_TMO_LAST);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_tmo       <= '0;
            r_frame     <= '0;
            r_frame_err <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_frame_err <= w_tmo_hit;
            r_ovf_err   <= w_drop;

            if (w_hs) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            if (w_store) begin
                case (r_idx)
                    OFS_PIX_X: r_frame.pix_x      <= rx_data;
                    OFS_PIX_Y: r_frame.pix_y      <= rx_data;
                    OFS_CXS_H: r_frame.cxs[15:8]  <= rx_data;
                    OFS_CXS_L: r_frame.cxs[7:0]   <= rx_data;
                    OFS_CYS_H: r_frame.cys[15:8]  <= rx_data;
                    OFS_CYS_L: r_frame.cys[7:0]   <= rx_data;
                    OFS_DCX_H: r_frame.dcx[15:8]  <= rx_data;
                    OFS_DCX_L: r_frame.dcx[7:0]   <= rx_data;
                    OFS_DCY_H: r_frame.dcy[15:8]  <= rx_data;
                    OFS_DCY_L: r_frame.dcy[7:0]   <= rx_data;
                    default:   ;
                endcase
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 4'd1;
            end else if (w_tmo_hit) begin
                r_idx <= '0;
            end

            // Gap counter only runs while a partial frame is open
            if (rx_valid || w_tmo_hit || !w_counting) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 16'd1;
            end
        end
    end

    assign frm.frame_valid = w_frame_valid;
    assign frm.pix_x       = r_frame.pix_x;
    assign frm.pix_y       = r_frame.pix_y;
    assign frm.cxs         = r_frame.cxs;
    assign frm.cys         = r_frame.cys;
    assign frm.dcx         = r_frame.dcx;
    assign frm.dcy         = r_frame.dcy;
    assign frame_err       = r_frame_err;
    assign ovf_err         = r_ovf_err;
    assign frame_cnt       = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mandel_param_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandel_param_rx
// Purpose  : Self-checking bench for mandel_param_rx. A frame-level reference
//            model (byte array, gap counter, pending flag) is advanced once
//            per clock edge and every output is compared after each edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mandel_param_rx;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       ovf_err;
    logic [7:0] frame_cnt;

    mandel_param_rx_if ifc ();

    mandel_param_rx #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frm       (ifc),
        .frame_err (frame_err),
        .ovf_err   (ovf_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_asm [10];
    int         m_idx;
    int         m_gap;
    int         m_cnt;
    bit         m_pend;
    bit         m_ferr;
    bit         m_oerr;
    bit         m_zero;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        m_asm[m_idx] = d;
        m_idx++;
        m_gap  = 0;
        m_zero = 0;
        if (m_idx == 10) begin
            m_pend = 1;
            m_idx  = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit rd);
        m_ferr = 0;
        m_oerr = 0;
        if (r) begin
            foreach (m_asm[k]) m_asm[k] = 8'h00;
            m_idx = 0; m_gap = 0; m_cnt = 0; m_pend = 0; m_zero = 1;
        end else if (m_pend) begin
            if (rd) begin
                m_pend = 0;
                m_cnt  = (m_cnt + 1) % 256;
                if (v) push_byte(d);
            end else if (v) begin
                m_oerr = 1;
            end
        end else if (v) begin
            push_byte(d);
        end else if (m_idx > 0) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_ferr = 1;
                m_idx  = 0;
                m_gap  = 0;
            end
        end
    endtask

    task automatic tick(input bit r, input bit v, input logic [7:0] d, input bit rd);
        rst             = r;
        rx_valid        = v;
        rx_data         = d;
        ifc.frame_ready = rd;
        @(posedge clk);
        model_step(r, v, d, rd);
        #1;
        chk("frame_valid", 32'(ifc.frame_valid), 32'(m_pend));
        chk("frame_err",   32'(frame_err),       32'(m_ferr));
        chk("ovf_err",     32'(ovf_err),         32'(m_oerr));
        chk("frame_cnt",   32'(frame_cnt),       32'(m_cnt));
        if (m_pend || m_zero) begin
            chk("pix_x", 32'(ifc.pix_x), 32'(m_asm[0]));
            chk("pix_y", 32'(ifc.pix_y), 32'(m_asm[1]));
            chk("cxs", {16'h0, ifc.cxs}, {16'h0, m_asm[2], m_asm[3]});
            chk("cys", {16'h0, ifc.cys}, {16'h0, m_asm[4], m_asm[5]});
            chk("dcx", {16'h0, ifc.dcx}, {16'h0, m_asm[6], m_asm[7]});
            chk("dcy", {16'h0, ifc.dcy}, {16'h0, m_asm[8], m_asm[9]});
        end
    endtask

    // Sends the first n bytes of f (byte 0 in f[79:72]), one idle cycle before each
    task automatic send_n(input logic [79:0] f, input int n, input bit rd);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 8'h00, rd);
            tick(0, 1, f[79-8*i -: 8], rd);
        end
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, rd);
    endtask

    initial begin
        logic [79:0] f;
        int          n;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ifc.frame_ready = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) tick(1, 0, 8'h00, 0);
        chk("rst_valid", 32'(ifc.frame_valid), 32'd0);
        chk("rst_cnt",   32'(frame_cnt),       32'd0);
        chk("rst_cxs",   {16'h0, ifc.cxs},     32'd0);

        // Reset mid-frame, then a clean frame with ready held high
        send_n(80'hAA_BB_CC_DD_EE_00_00_00_00_00, 5, 1);
        tick(1, 0, 8'h00, 1);
        send_n(80'h03_04_F0_00_F8_00_00_40_00_40, 10, 1);
        chk("d1_valid", 32'(ifc.frame_valid), 32'd1);
        chk("d1_pix_x", 32'(ifc.pix_x), 32'h03);
        chk("d1_pix_y", 32'(ifc.pix_y), 32'h04);
        chk("d1_cxs", {16'h0, ifc.cxs}, 32'hF000);
        chk("d1_cys", {16'h0, ifc.cys}, 32'hF800);
        chk("d1_dcx", {16'h0, ifc.dcx}, 32'h0040);
        chk("d1_dcy", {16'h0, ifc.dcy}, 32'h0040);
        idle(1, 1);
        chk("d1_valid_fall", 32'(ifc.frame_valid), 32'd0);
        chk("d1_cnt", 32'(frame_cnt), 32'd1);

        // Backpressure: extra byte while pending is dropped
        send_n(80'h11_22_33_44_55_66_77_88_99_AA, 10, 0);
        idle(1, 0);
        tick(0, 1, 8'h55, 0);
        chk("bp_ovf", 32'(ovf_err), 32'd1);
        chk("bp_pix_x_held", 32'(ifc.pix_x), 32'h11);
        idle(1, 1);
        chk("bp_cnt", 32'(frame_cnt), 32'd2);
        send_n(80'h21_22_23_24_25_26_27_28_29_2A, 10, 1);
        chk("bp_next_dcy", {16'h0, ifc.dcy}, 32'h292A);
        idle(1, 1);

        // Timeout discards a partial frame
        send_n(80'h99_98_97_00_00_00_00_00_00_00, 3, 1);
        idle(TMO, 1);
        chk("to_ferr", 32'(frame_err), 32'd1);
        send_n(80'h04_05_F8_00_FC_00_00_10_00_20, 10, 1);
        chk("to_cxs", {16'h0, ifc.cxs}, 32'hF800);
        chk("to_cys", {16'h0, ifc.cys}, 32'hFC00);
        chk("to_dcx", {16'h0, ifc.dcx}, 32'h0010);
        chk("to_dcy", {16'h0, ifc.dcy}, 32'h0020);
        idle(1, 1);

        // Timeout boundary: byte in the expiry cycle is kept
        send_n(80'h31_32_33_34_35_36_37_38_39_3A, 3, 1);
        idle(TMO - 1, 1);
        tick(0, 1, 8'h34, 1);
        chk("tb_no_ferr", 32'(frame_err), 32'd0);
        for (int i = 4; i < 10; i++) begin
            tick(0, 0, 8'h00, 1);
            tick(0, 1, 8'(8'h31 + i), 1);
        end
        chk("tb_valid", 32'(ifc.frame_valid), 32'd1);
        chk("tb_dcy", {16'h0, ifc.dcy}, 32'h393A);
        idle(1, 1);

        // Handshake coincident with a new byte
        send_n(80'h41_42_43_44_45_46_47_48_49_4A, 10, 0);
        idle(1, 0);
        tick(0, 1, 8'h07, 1);
        chk("co_ovf", 32'(ovf_err), 32'd0);
        send_n(80'h08_09_0A_0B_0C_0D_0E_0F_10_00, 9, 1);
        chk("co_pix_x", 32'(ifc.pix_x), 32'h07);
        idle(1, 1);

        // frame_cnt wrap after 256 accepted frames
        tick(1, 0, 8'h00, 1);
        for (int fr = 0; fr < 256; fr++) begin
            f = {$urandom, $urandom, 16'($urandom)};
            send_n(f, 10, 1);
        end
        idle(1, 1);
        chk("wrap_cnt", 32'(frame_cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                n = TMO - 2 + int'($urandom_range(0, 4));
                idle(n, bit'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 1499) == 0) begin
                tick(1, 0, 8'h00, 0);
            end else begin
                tick(0, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
